// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: sole owner of the register-file write port.
// After reset it clears every register to zero, then grants writes
// round-robin between ALU writeback (req0) and load writeback (req1).
// Writes aimed at register 0 are swallowed and flagged on zero_drop.
// Cycles in which both requesters compete are counted for perf debug.
module rf_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              init_done,
  output logic              zero_drop,
  output logic [CNT_W-1:0]  contention_cnt
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_write_reg;
  logic [DATA_W-1:0]   r_write_data;
  logic                r_reg_write;
  logic                r_init_done;
  logic                r_zero_drop;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_run;
  logic                w_both;
  logic                w_grant;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_sel_reg;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_run  = (r_state == S_RUN);
  assign w_both = req0_valid & req1_valid;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    // NOTE: default first so every path assigns w_grant and no latch is inferred.
    w_grant = 1'b0;
    if (w_both)
      w_grant = ~r_last_grant;
    else if (req1_valid)
      w_grant = 1'b1;
  end

  assign req0_ready = w_run & req0_valid & ~w_grant;
  assign req1_ready = w_run & req1_valid &  w_grant;
  assign w_xfer     = req0_ready | req1_ready;
  assign w_sel_reg  = w_grant ? req1_reg  : req0_reg;
  assign w_sel_data = w_grant ? req1_data : req0_data;

  // Clear sequencer, write-port registers and contention counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values regardless of statement order.
      r_state      <= S_CLEAR;
      r_clr_idx    <= '0;
      r_last_grant <= 1'b1;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_reg_write  <= 1'b0;
      r_init_done  <= 1'b0;
      r_zero_drop  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_reg_write  <= 1'b1;
          r_write_reg  <= r_clr_idx;
          r_write_data <= '0;
          r_zero_drop  <= 1'b0;
          r_clr_idx    <= r_clr_idx + ADDR_W'(1);
          if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_both && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
          if (w_xfer) begin
            r_write_reg  <= w_sel_reg;
            r_write_data <= w_sel_data;
            r_last_grant <= w_grant;
            r_reg_write  <= (w_sel_reg != '0);
            r_zero_drop  <= (w_sel_reg == '0);
          end else begin
            r_reg_write  <= 1'b0;
            r_zero_drop  <= 1'b0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign WriteReg       = r_write_reg;
  assign WriteData      = r_write_data;
  assign RegWrite       = r_reg_write;
  assign init_done      = r_init_done;
  assign zero_drop      = r_zero_drop;
  assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a
// randomized stream compared against a transaction-level reference model.
module tb_rf_write_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 4;   // narrow so saturation is reachable quickly

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_reg = '0, req1_reg = '0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite, init_done, zero_drop;
  logic [CNT_W-1:0]  contention_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_reg(req1_reg), .req1_data(req1_data),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .init_done(init_done), .zero_drop(zero_drop),
    .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  // Register file as driven by the DUT's write port (not reset, like the real array).
  logic [DATA_W-1:0] tb_rf [NUM_REGS];
  always @(posedge clk)
    if (RegWrite) tb_rf[WriteReg] <= WriteData;

  // ---------------- reference model ----------------
  // Winner of a cycle: -1 none, 0 or 1; ties go to whoever did not win last.
  function automatic int pick(bit v0, bit v1, int last);
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  int                m_clr  = 0;
  bit                m_run  = 1'b0;
  int                m_last = 1;
  logic              m_we   = 1'b0, m_zd = 1'b0, m_init = 1'b0;
  logic [ADDR_W-1:0] m_wreg  = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [CNT_W-1:0]  m_cnt   = '0;
  logic [DATA_W-1:0] m_rf [NUM_REGS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clr <= 0; m_run <= 1'b0; m_last <= 1;
      m_we <= 1'b0; m_zd <= 1'b0; m_init <= 1'b0;
      m_wreg <= '0; m_wdata <= '0; m_cnt <= '0;
    end else begin
      if (m_we) m_rf[m_wreg] <= m_wdata;
      if (!m_run) begin
        m_we <= 1'b1; m_zd <= 1'b0;
        m_wreg <= ADDR_W'(m_clr); m_wdata <= '0;
        m_clr <= m_clr + 1;
        if (m_clr == NUM_REGS - 1) begin m_run <= 1'b1; m_init <= 1'b1; end
      end else begin
        if (req0_valid && req1_valid && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
        case (pick(req0_valid, req1_valid, m_last))
          0: begin
            m_wreg <= req0_reg; m_wdata <= req0_data; m_last <= 0;
            m_we <= (req0_reg != 0); m_zd <= (req0_reg == 0);
          end
          1: begin
            m_wreg <= req1_reg; m_wdata <= req1_data; m_last <= 1;
            m_we <= (req1_reg != 0); m_zd <= (req1_reg == 0);
          end
          default: begin m_we <= 1'b0; m_zd <= 1'b0; end
        endcase
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin
      tb_rf[i] = 32'hBAD0_0000 + i;
      m_rf[i]  = 32'hBAD0_0000 + i;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({RegWrite, WriteReg, WriteData, init_done, zero_drop, contention_cnt, req0_ready, req1_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got RegWrite=%b WriteReg=%0d WriteData=%h init_done=%b zero_drop=%b cnt=%0d rdy=%b%b, expected all 0",
               RegWrite, WriteReg, WriteData, init_done, zero_drop, contention_cnt, req0_ready, req1_ready);
    end
    req1_valid = 1'b0;
    req0_reg = 5'd7; req0_data = 32'hA5A5_0007;
  endtask

  // Release reset with req0 already waiting; verify the 32-entry clear.
  task automatic test_clear_with_pending();
    int nz;
    rst_n = 1'b1;
    for (int k = 1; k <= NUM_REGS; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({RegWrite, WriteReg, WriteData, init_done, req0_ready, req1_ready} !==
          {1'b1, ADDR_W'(k - 1), 32'h0, (k == NUM_REGS), (k == NUM_REGS), 1'b0}) begin
        n_fail++;
        $display("FAIL clear_step%0d: got we=%b idx=%0d data=%h done=%b rdy=%b%b, expected we=1 idx=%0d data=0 done=%b rdy=%b0",
                 k, RegWrite, WriteReg, WriteData, init_done, req0_ready, req1_ready,
                 k - 1, (k == NUM_REGS), (k == NUM_REGS));
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd7, 32'hA5A5_0007}) begin
      n_fail++;
      $display("FAIL first_run_accept: got we=%b reg=%0d data=%h, expected 1 7 a5a50007", RegWrite, WriteReg, WriteData);
    end
    nz = 0;
    for (int i = 0; i < NUM_REGS; i++) if (tb_rf[i] !== 32'h0) nz++;
    n_checks++;
    if (nz != 0) begin
      n_fail++;
      $display("FAIL clear_rf_zero: %0d entries nonzero, expected 0", nz);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h0000_1234;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    @(negedge clk); #1;
    req0_valid = 1'b0;
    n_checks++;
    if ({RegWrite, zero_drop, WriteReg, WriteData} !== {1'b1, 1'b0, 5'd5, 32'h0000_1234}) begin
      n_fail++;
      $display("FAIL single_write: got we=%b zd=%b reg=%0d data=%h expected 1 0 5 00001234", RegWrite, zero_drop, WriteReg, WriteData);
    end
    @(negedge clk); #1;
    n_checks++;
    if (tb_rf[5] !== 32'h0000_1234 || RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL single_readback: got rf5=%h we=%b expected 00001234 0", tb_rf[5], RegWrite);
    end
    // A lone req1 write leaves req1 as last winner, so the next tie goes to req0.
    req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'h9999_0009;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL single_ready1: got %b%b expected 01", req0_ready, req1_ready);
    end
    @(negedge clk); #1;
    req1_valid = 1'b0;
    n_checks++;
    if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd9, 32'h9999_0009}) begin
      n_fail++; $display("FAIL single_write1: got we=%b reg=%0d data=%h expected 1 9 99990009", RegWrite, WriteReg, WriteData);
    end
  endtask

  task automatic test_contention();
    int h0 = 0, h1 = 0;
    logic [ADDR_W-1:0] acc_reg;
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h1000_0001;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'h2000_0002;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention_grant%0d: got %b%b expected %s", c, req0_ready, req1_ready, (c % 2 == 0) ? "10" : "01");
      end
      h0 += int'(req0_ready); h1 += int'(req1_ready);
      acc_reg = (c % 2 == 0) ? req0_reg : req1_reg;
      @(negedge clk); #1;
      n_checks++;
      if ({RegWrite, WriteReg} !== {1'b1, acc_reg}) begin
        n_fail++; $display("FAIL contention_write%0d: got we=%b reg=%0d expected 1 %0d", c, RegWrite, WriteReg, acc_reg);
      end
      if (c % 2 == 0) begin req0_reg = req0_reg + 5'd2; req0_data = req0_data + 1; end
      else begin req1_reg = req1_reg + 5'd2; req1_data = req1_data + 1; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (contention_cnt !== CNT_W'(4) || h0 != 2 || h1 != 2) begin
      n_fail++; $display("FAIL contention_count: got cnt=%0d h0=%0d h1=%0d expected 4 2 2", contention_cnt, h0, h1);
    end
  endtask

  task automatic test_zero_drop();
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL zero_ready: got %b%b expected 01", req0_ready, req1_ready);
    end
    @(negedge clk); #1;
    req1_valid = 1'b0;
    n_checks++;
    if ({RegWrite, zero_drop, WriteReg, WriteData} !== {1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL zero_drop: got we=%b zd=%b reg=%0d data=%h expected 0 1 0 ffffffff", RegWrite, zero_drop, WriteReg, WriteData);
    end
    @(negedge clk); #1;
    n_checks++;
    if (zero_drop !== 1'b0 || tb_rf[0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_pulse_rf0: got zd=%b rf0=%h expected 0 0", zero_drop, tb_rf[0]);
    end
  endtask

  task automatic test_saturation();
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h3333_3333;
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'h4444_4444;
    repeat (20) @(negedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (contention_cnt !== {CNT_W{1'b1}}) begin
      n_fail++; $display("FAIL contention_saturate: got %0d expected %0d", contention_cnt, {CNT_W{1'b1}});
    end
  endtask

  task automatic test_random(input int cycles);
    bit p0 = 1'b0, p1 = 1'b0;
    bit e0, e1;
    int g, bad;
    logic [2*ADDR_W+DATA_W+CNT_W:0] got_v, exp_v;
    for (int n = 0; n < cycles; n++) begin
      if (!(req0_valid && !p0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        req0_data  = $urandom;
      end
      if (!(req1_valid && !p1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        req1_data  = $urandom;
      end
      #1;
      g  = pick(req0_valid, req1_valid, m_last);
      e0 = m_run && g == 0;
      e1 = m_run && g == 1;
      got_v = {req0_ready, req1_ready, RegWrite, zero_drop, init_done, WriteReg, WriteData, contention_cnt};
      exp_v = {e0, e1, m_we, m_zd, m_init, m_wreg, m_wdata, m_cnt};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", n, got_v, exp_v);
      end
      p0 = e0; p1 = e1;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    bad = 0;
    for (int i = 0; i < NUM_REGS; i++) if (tb_rf[i] !== m_rf[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL random_rf_contents: %0d entries differ from model, expected 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    req0_valid = 1'b1; req0_reg = 5'd12; req0_data = 32'hC0DE_000C;
    req1_valid = 1'b1; req1_reg = 5'd13; req1_data = 32'hC0DE_000D;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_pre: got we=%b expected 1", RegWrite);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({RegWrite, init_done, zero_drop, contention_cnt, req0_ready, req1_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got we=%b done=%b zd=%b cnt=%0d rdy=%b%b expected all 0",
               RegWrite, init_done, zero_drop, contention_cnt, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= NUM_REGS; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({RegWrite, WriteReg, WriteData, init_done} !== {1'b1, ADDR_W'(k - 1), 32'h0, (k == NUM_REGS)}) begin
        n_fail++;
        $display("FAIL reclear_step%0d: got we=%b idx=%0d data=%h done=%b expected 1 %0d 0 %b",
                 k, RegWrite, WriteReg, WriteData, init_done, k - 1, (k == NUM_REGS));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_with_pending();
    test_single_write();
    test_contention();
    test_zero_drop();
    test_saturation();
    test_random(400);
    test_mid_reset();
    test_random(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
